nios_button_pio: RTL

Parametrised, debounced input PIO for the Nios II system bus: up to 32 push-button/switch channels with per-channel two-flop synchronisation, counter-based debounce, edge capture and a maskable interrupt in either level or edge mode. It sits on the Avalon-MM slave side of the Nios interconnect, in place of the plain input-port PIO, and feeds the CPU IRQ line.

---
 rtl/nios_button_pio.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nios_button_pio.sv
// Debounced Avalon-MM input PIO: per-channel synchroniser, counter debounce,
// edge capture with write-1-to-clear, and a maskable level- or edge-driven IRQ.
module nios_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0,
    parameter int IRQ_MODE        = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] event_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;
    logic             wdata_unused_s;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign wr_s           = chipselect & ~write_n;
    assign wdata_unused_s = ^writedata;

    // Synchroniser and per-channel debounce counters
    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Edge events, capture register, mask register and read mux
    always_comb begin
        case (EDGE_MODE)
            0:       event_s = stable_d & ~stable_q;
            1:       event_s = ~stable_d & stable_q;
            default: event_s = stable_d ^ stable_q;
        endcase

        if (wr_s && (address == 2'd3)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        // A new event in the same cycle as a clear keeps the bit set
        edge_d = (edge_q & ~clr_s) | event_s;

        if (wr_s && (address == 2'd2)) begin
            mask_d = writedata[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end

        case (address)
            2'd0:    readdata_d = zext(stable_q);
            2'd1:    readdata_d = zext(sync2_q);
            2'd2:    readdata_d = zext(mask_q);
            2'd3:    readdata_d = zext(edge_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= 32'd0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = (IRQ_MODE == 1) ? |(edge_q & mask_q) : |(stable_q & mask_q);

endmodule
